// File: rtl/pc_trap_unit.sv
// pc_trap_unit: next-PC sequencer that owns the PC and the user-mode CSRs.
// It handles prioritised exceptions, vectored user interrupts, URET and a
// double-fault halt.
//
// Ports:
//   iCLK, iRST             clock, synchronous active-high reset
//   iStall                 freeze PC, FSM and CSRs (uip still samples)
//   iOrigPC, iBranch       next-PC select (PC+4 / branch / jal / jalr), branch taken
//   iImm, iRs1             immediate and rs1 for target generation
//   iIllegal, iEcall, iUret, iLoadMis, iStoreMis, iBadAddr   trap sources
//   iIrq                   level-sensitive interrupt lines
//   iCsrWe/Addr/WData      CSR write port; oCsrRData is the combinational read
//   oPC, oPC4              current PC and PC+4
//   oTrap                  current instruction trapped (combinational)
//   oInHandler, oHalted    FSM status
module pc_trap_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h0040_0000),
    parameter int unsigned     N_IRQ    = 4
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iStall,
    input  logic [1:0]       iOrigPC,
    input  logic             iBranch,
    input  logic [XLEN-1:0]  iImm,
    input  logic [XLEN-1:0]  iRs1,
    input  logic             iIllegal,
    input  logic             iEcall,
    input  logic             iUret,
    input  logic             iLoadMis,
    input  logic             iStoreMis,
    input  logic [XLEN-1:0]  iBadAddr,
    input  logic [N_IRQ-1:0] iIrq,
    input  logic             iCsrWe,
    input  logic [11:0]      iCsrAddr,
    input  logic [XLEN-1:0]  iCsrWData,
    output logic [XLEN-1:0]  oCsrRData,
    output logic [XLEN-1:0]  oPC,
    output logic [XLEN-1:0]  oPC4,
    output logic             oTrap,
    output logic             oInHandler,
    output logic             oHalted
);

    localparam int unsigned IDXW      = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
    localparam logic [11:0] A_USTATUS = 12'h000;
    localparam logic [11:0] A_UIE     = 12'h004;
    localparam logic [11:0] A_UTVEC   = 12'h005;
    localparam logic [11:0] A_USCRATCH= 12'h040;
    localparam logic [11:0] A_UEPC    = 12'h041;
    localparam logic [11:0] A_UCAUSE  = 12'h042;
    localparam logic [11:0] A_UTVAL   = 12'h043;
    localparam logic [11:0] A_UIP     = 12'h044;

    typedef enum logic [1:0] {ST_RUN, ST_HANDLER, ST_HALT} state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic              uie_bit_q, uie_bit_d;
    logic              upie_q, upie_d;
    logic [N_IRQ-1:0]  uie_q, uie_d;
    logic [N_IRQ-1:0]  uip_q, uip_d;
    logic [XLEN-1:0]   utvec_q, utvec_d;
    logic [XLEN-1:0]   uscratch_q, uscratch_d;
    logic [XLEN-1:0]   uepc_q, uepc_d;
    logic [XLEN-1:0]   ucause_q, ucause_d;
    logic [XLEN-1:0]   utval_q, utval_d;

    logic [XLEN-1:0]   pc_plus4, br_tgt, jalr_sum, jump_tgt, seq_next;
    logic [XLEN-1:0]   exc_cause, exc_tval, utvec_base, trap_pc;
    logic              jump_taken, inst_mis, exc_any, irq_elig, active, trap_c, csr_we;
    logic [N_IRQ-1:0]  irq_pend;
    logic [IDXW-1:0]   irq_idx;

    // Target generation and next sequential PC
    assign pc_plus4 = pc_q + XLEN'(4);
    assign br_tgt   = pc_q + iImm;
    assign jalr_sum = iRs1 + iImm;

    always_comb begin
        jump_taken = 1'b0;
        jump_tgt   = br_tgt;
        case (iOrigPC)
            2'b01:   jump_taken = iBranch;
            2'b10:   jump_taken = 1'b1;
            2'b11: begin
                jump_taken = 1'b1;
                jump_tgt   = jalr_sum & ~XLEN'(1);
            end
            default: jump_taken = 1'b0;
        endcase
    end

    assign seq_next = jump_taken ? jump_tgt : pc_plus4;
    assign inst_mis = jump_taken && (jump_tgt[1:0] != 2'b00);
    assign exc_any  = inst_mis | iIllegal | iEcall | iLoadMis | iStoreMis;

    // Exception cause/tval in priority order
    always_comb begin
        exc_cause = '0;
        exc_tval  = '0;
        if (inst_mis) begin
            exc_cause = XLEN'(0);
            exc_tval  = jump_tgt;
        end else if (iIllegal) begin
            exc_cause = XLEN'(2);
        end else if (iEcall) begin
            exc_cause = XLEN'(8);
        end else if (iLoadMis) begin
            exc_cause = XLEN'(4);
            exc_tval  = iBadAddr;
        end else if (iStoreMis) begin
            exc_cause = XLEN'(6);
            exc_tval  = iBadAddr;
        end
    end

    // Lowest pending interrupt index wins
    assign irq_pend = uie_q & uip_q;
    always_comb begin
        irq_idx = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (irq_pend[i]) irq_idx = IDXW'(i);
        end
    end

    assign irq_elig   = uie_bit_q && (|irq_pend) && !exc_any;
    assign active     = !iStall && (state_q != ST_HALT);
    assign trap_c     = active && (exc_any || irq_elig);
    assign utvec_base = {utvec_q[XLEN-1:2], 2'b00};
    assign trap_pc    = (!exc_any && utvec_q[0]) ? utvec_base + XLEN'({irq_idx, 2'b00})
                                                 : utvec_base;

    // A same-cycle URET owns ustatus/uepc, so writes to them are dropped
    assign csr_we = iCsrWe && !trap_c
                    && !(iUret && (iCsrAddr == A_USTATUS || iCsrAddr == A_UEPC));

    // CSR read mux
    always_comb begin
        oCsrRData = '0;
        case (iCsrAddr)
            A_USTATUS: begin
                oCsrRData[0] = uie_bit_q;
                oCsrRData[4] = upie_q;
            end
            A_UIE:      oCsrRData = XLEN'(uie_q);
            A_UTVEC:    oCsrRData = utvec_q;
            A_USCRATCH: oCsrRData = uscratch_q;
            A_UEPC:     oCsrRData = uepc_q;
            A_UCAUSE:   oCsrRData = ucause_q;
            A_UTVAL:    oCsrRData = utval_q;
            A_UIP:      oCsrRData = XLEN'(uip_q);
            default:    oCsrRData = '0;
        endcase
    end

    // Next-state: FSM, PC and CSRs
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        uie_bit_d  = uie_bit_q;
        upie_d     = upie_q;
        uie_d      = uie_q;
        utvec_d    = utvec_q;
        uscratch_d = uscratch_q;
        uepc_d     = uepc_q;
        ucause_d   = ucause_q;
        utval_d    = utval_q;
        uip_d      = (state_q == ST_HALT) ? uip_q : iIrq;

        if (active) begin
            if (csr_we) begin
                case (iCsrAddr)
                    A_USTATUS: begin
                        uie_bit_d = iCsrWData[0];
                        upie_d    = iCsrWData[4];
                    end
                    A_UIE:      uie_d      = iCsrWData[N_IRQ-1:0];
                    A_UTVEC:    utvec_d    = {iCsrWData[XLEN-1:2], 1'b0, iCsrWData[0]};
                    A_USCRATCH: uscratch_d = iCsrWData;
                    A_UEPC:     uepc_d     = {iCsrWData[XLEN-1:2], 2'b00};
                    A_UCAUSE:   ucause_d   = iCsrWData;
                    A_UTVAL:    utval_d    = iCsrWData;
                    default:    ;
                endcase
            end

            if (exc_any && state_q == ST_HANDLER) begin
                state_d = ST_HALT;
            end else if (trap_c) begin
                uepc_d    = {pc_q[XLEN-1:2], 2'b00};
                ucause_d  = exc_any ? exc_cause : {1'b1, (XLEN-1)'(irq_idx)};
                utval_d   = exc_any ? exc_tval : '0;
                upie_d    = uie_bit_q;
                uie_bit_d = 1'b0;
                pc_d      = trap_pc;
                state_d   = ST_HANDLER;
            end else if (iUret) begin
                pc_d      = uepc_q;
                uie_bit_d = upie_q;
                upie_d    = 1'b1;
                state_d   = ST_RUN;
            end else begin
                pc_d = seq_next;
            end
        end
    end

    // State registers
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            uie_bit_q  <= 1'b0;
            upie_q     <= 1'b0;
            uie_q      <= '0;
            uip_q      <= '0;
            utvec_q    <= {RESET_PC[XLEN-1:2], 1'b0, RESET_PC[0]};
            uscratch_q <= '0;
            uepc_q     <= '0;
            ucause_q   <= '0;
            utval_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            uie_bit_q  <= uie_bit_d;
            upie_q     <= upie_d;
            uie_q      <= uie_d;
            uip_q      <= uip_d;
            utvec_q    <= utvec_d;
            uscratch_q <= uscratch_d;
            uepc_q     <= uepc_d;
            ucause_q   <= ucause_d;
            utval_q    <= utval_d;
        end
    end

    assign oPC        = pc_q;
    assign oPC4       = pc_plus4;
    assign oTrap      = trap_c;
    assign oInHandler = (state_q == ST_HANDLER);
    assign oHalted    = (state_q == ST_HALT);

endmodule

// File: tb/tb_pc_trap_unit.sv
// Testbench for pc_trap_unit: directed stimulus, a behavioural model checked
// every negedge, plus literal expectations at key points.
module tb_pc_trap_unit;

    logic        iCLK = 1'b0;
    logic        iRST, iStall, iBranch, iIllegal, iEcall, iUret, iLoadMis, iStoreMis, iCsrWe;
    logic [1:0]  iOrigPC;
    logic [31:0] iImm, iRs1, iBadAddr, iCsrWData;
    logic [3:0]  iIrq;
    logic [11:0] iCsrAddr;
    logic [31:0] oCsrRData, oPC, oPC4;
    logic        oTrap, oInHandler, oHalted;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    pc_trap_unit dut (
        .iCLK(iCLK), .iRST(iRST), .iStall(iStall), .iOrigPC(iOrigPC), .iBranch(iBranch),
        .iImm(iImm), .iRs1(iRs1), .iIllegal(iIllegal), .iEcall(iEcall), .iUret(iUret),
        .iLoadMis(iLoadMis), .iStoreMis(iStoreMis), .iBadAddr(iBadAddr), .iIrq(iIrq),
        .iCsrWe(iCsrWe), .iCsrAddr(iCsrAddr), .iCsrWData(iCsrWData), .oCsrRData(oCsrRData),
        .oPC(oPC), .oPC4(oPC4), .oTrap(oTrap), .oInHandler(oInHandler), .oHalted(oHalted)
    );

    always #5 iCLK = ~iCLK;

    // Behavioural model state: 0 = running, 1 = in handler, 2 = halted
    int          m_st;
    logic [31:0] m_pc, m_ustatus, m_uie, m_utvec, m_uscratch, m_uepc, m_ucause, m_utval, m_uip;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h000: return m_ustatus;
            12'h004: return m_uie;
            12'h005: return m_utvec;
            12'h040: return m_uscratch;
            12'h041: return m_uepc;
            12'h042: return m_ucause;
            12'h043: return m_utval;
            12'h044: return m_uip;
            default: return 32'h0;
        endcase
    endfunction

    // What the spec says should happen this cycle, from model state + inputs
    task automatic m_decide(output bit trap, output bit exc, output logic [31:0] cause,
                            output logic [31:0] tval, output logic [31:0] nxt,
                            output logic [31:0] tpc);
        bit jump;
        logic [31:0] tgt;
        int idx;
        jump = (iOrigPC == 2'd2) || (iOrigPC == 2'd3) || (iOrigPC == 2'd1 && iBranch);
        tgt  = (iOrigPC == 2'd3) ? ((iRs1 + iImm) & 32'hFFFF_FFFE) : (m_pc + iImm);
        nxt  = jump ? tgt : m_pc + 32'd4;
        exc  = 1'b1;
        tval = 32'h0;
        cause = 32'h0;
        if (jump && (tgt % 4) != 0) begin cause = 0; tval = tgt; end
        else if (iIllegal)          cause = 2;
        else if (iEcall)            cause = 8;
        else if (iLoadMis)  begin cause = 4; tval = iBadAddr; end
        else if (iStoreMis) begin cause = 6; tval = iBadAddr; end
        else exc = 1'b0;
        trap = exc;
        tpc  = m_utvec & 32'hFFFF_FFFC;
        if (!exc && m_ustatus[0] && (m_uie & m_uip) != 0) begin
            idx = 0;
            while (((m_uie & m_uip) >> idx) % 2 == 0) idx++;
            trap  = 1'b1;
            cause = 32'h8000_0000 + idx;
            if (m_utvec[0]) tpc = tpc + 4 * idx;
        end
    endtask

    // Model update on every active edge
    always @(posedge iCLK) begin : model
        bit trap, exc, was_halted;
        logic [31:0] cause, tval, nxt, tpc;
        if (iRST) begin
            m_st = 0; m_pc = 32'h0040_0000; m_utvec = 32'h0040_0000;
            m_ustatus = 0; m_uie = 0; m_uscratch = 0; m_uepc = 0;
            m_ucause = 0; m_utval = 0; m_uip = 0;
        end else begin
            m_decide(trap, exc, cause, tval, nxt, tpc);
            was_halted = (m_st == 2);
            if (!was_halted && !iStall) begin
                if (exc && m_st == 1) begin
                    m_st = 2;
                end else if (trap) begin
                    m_uepc = m_pc & 32'hFFFF_FFFC;
                    m_ucause = cause;
                    m_utval = tval;
                    m_ustatus = m_ustatus[0] ? 32'h10 : 32'h0;
                    m_pc = tpc;
                    m_st = 1;
                end else begin
                    if (iCsrWe && !(iUret && (iCsrAddr == 12'h000 || iCsrAddr == 12'h041))) begin
                        case (iCsrAddr)
                            12'h000: m_ustatus  = iCsrWData & 32'h11;
                            12'h004: m_uie      = iCsrWData & 32'hF;
                            12'h005: m_utvec    = iCsrWData & 32'hFFFF_FFFD;
                            12'h040: m_uscratch = iCsrWData;
                            12'h041: m_uepc     = iCsrWData & 32'hFFFF_FFFC;
                            12'h042: m_ucause   = iCsrWData;
                            12'h043: m_utval    = iCsrWData;
                            default: ;
                        endcase
                    end
                    if (iUret) begin
                        m_pc = m_uepc;
                        m_ustatus = 32'h10 | (m_ustatus[4] ? 32'h1 : 32'h0);
                        m_st = 0;
                    end else begin
                        m_pc = nxt;
                    end
                end
            end
            if (!was_halted) m_uip = {28'h0, iIrq};
        end
    end

    // Compare process: every negedge once the model is valid
    always @(negedge iCLK) begin : compare
        bit trap, exc;
        logic [31:0] cause, tval, nxt, tpc;
        if (chk_en) begin
            m_decide(trap, exc, cause, tval, nxt, tpc);
            check("m_oPC", oPC, m_pc);
            check("m_oPC4", oPC4, m_pc + 32'd4);
            check("m_oTrap", {31'h0, oTrap}, {31'h0, trap && !iStall && m_st != 2});
            check("m_oInHandler", {31'h0, oInHandler}, {31'h0, m_st == 1});
            check("m_oHalted", {31'h0, oHalted}, {31'h0, m_st == 2});
            check("m_oCsrRData", oCsrRData, m_read(iCsrAddr));
        end
    end

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    task automatic clr();
        iStall = 0; iOrigPC = 0; iBranch = 0; iImm = 0; iRs1 = 0; iIllegal = 0;
        iEcall = 0; iUret = 0; iLoadMis = 0; iStoreMis = 0; iBadAddr = 0;
        iCsrWe = 0; iCsrAddr = 0; iCsrWData = 0;
    endtask

    task automatic rd(input string name, input logic [11:0] a, input logic [31:0] exp);
        iCsrAddr = a;
        #1;
        check(name, oCsrRData, exp);
    endtask

    initial begin
        clr();
        iIrq = 0;
        iRST = 1;
        step(); step();
        iRST = 0;
        chk_en = 1'b1;
        check("rst_pc", oPC, 32'h0040_0000);
        check("rst_flags", {29'h0, oTrap, oInHandler, oHalted}, 32'h0);

        // Sequential fetch
        step(); check("seq_pc1", oPC, 32'h0040_0004);
        step(); check("seq_pc2", oPC, 32'h0040_0008);
        step(); check("seq_pc3", oPC, 32'h0040_000C);
        step(); check("seq_pc4", oPC, 32'h0040_0010);

        // Misaligned jal
        iOrigPC = 2'd2; iImm = 32'h6;
        #1; check("jal_mis_trap", {31'h0, oTrap}, 32'h1);
        step(); clr();
        rd("jal_ucause", 12'h042, 32'h0);
        rd("jal_utval", 12'h043, 32'h0040_0016);
        rd("jal_uepc", 12'h041, 32'h0040_0010);
        check("jal_pc", oPC, 32'h0040_0000);
        check("jal_inh", {31'h0, oInHandler}, 32'h1);

        // Return, then program vectored interrupts
        iUret = 1; step(); clr();
        check("uret1_pc", oPC, 32'h0040_0010);
        iCsrWe = 1; iCsrAddr = 12'h005; iCsrWData = 32'h0040_0101; step();
        iCsrAddr = 12'h004; iCsrWData = 32'h6; step();
        iCsrAddr = 12'h000; iCsrWData = 32'h1; step();
        iCsrWe = 0; iIrq = 4'b1100;
        #1; check("irq_uip_latency", {31'h0, oTrap}, 32'h0);
        step();
        check("irq_pc_before", oPC, 32'h0040_0020);
        check("irq_trap", {31'h0, oTrap}, 32'h1);
        step();
        check("irq_vec_pc", oPC, 32'h0040_0108);
        rd("irq_ucause", 12'h042, 32'h8000_0002);
        rd("irq_ustatus", 12'h000, 32'h10);
        rd("irq_uepc", 12'h041, 32'h0040_0020);

        // URET with a colliding uepc write
        iIrq = 0; iUret = 1; iCsrWe = 1; iCsrAddr = 12'h041; iCsrWData = 32'h1234;
        step(); clr();
        check("uret2_pc", oPC, 32'h0040_0020);
        check("uret2_inh", {31'h0, oInHandler}, 32'h0);
        rd("uret2_ustatus", 12'h000, 32'h11);
        rd("uret2_uepc", 12'h041, 32'h0040_0020);

        // Double fault halts
        iEcall = 1; step(); iEcall = 0;
        check("ecall_pc", oPC, 32'h0040_0100);
        rd("ecall_ucause", 12'h042, 32'h8);
        iIllegal = 1;
        #1; check("dbl_trap", {31'h0, oTrap}, 32'h1);
        step(); clr();
        check("halt_flag", {31'h0, oHalted}, 32'h1);
        iOrigPC = 2'd2; iImm = 32'h40; iUret = 1; iEcall = 1;
        iCsrWe = 1; iCsrAddr = 12'h040; iCsrWData = 32'hFFFF_FFFF;
        for (int i = 0; i < 10; i++) begin
            step();
            check("halt_pc", oPC, 32'h0040_0100);
        end
        clr();
        rd("halt_scratch", 12'h040, 32'h0);
        iRST = 1; step(); iRST = 0;
        check("halt_rst_pc", oPC, 32'h0040_0000);
        check("halt_rst_flag", {30'h0, oHalted, oInHandler}, 32'h0);
        rd("rst_utvec", 12'h005, 32'h0040_0000);

        // Stall blocks trap, CSR write and PC update
        iStall = 1; iEcall = 1; iCsrWe = 1; iCsrAddr = 12'h040; iCsrWData = 32'hDEAD_BEEF;
        #1; check("stall_trap", {31'h0, oTrap}, 32'h0);
        step();
        check("stall_pc", oPC, 32'h0040_0000);
        check("stall_scratch", oCsrRData, 32'h0);
        iStall = 0;
        #1; check("unstall_trap", {31'h0, oTrap}, 32'h1);
        step(); clr();
        rd("unstall_ucause", 12'h042, 32'h8);
        rd("trap_drops_write", 12'h040, 32'h0);
        iUret = 1; step(); clr();

        // Target boundaries and exception priority
        iOrigPC = 2'd1; iBranch = 0; iImm = 32'h2;
        #1; check("br_nt_mis", {31'h0, oTrap}, 32'h0);
        step(); check("br_nt_pc", oPC, 32'h0040_0004);
        iBranch = 1; iImm = 32'h8; step();
        check("br_t_pc", oPC, 32'h0040_000C);
        iOrigPC = 2'd3; iRs1 = 32'h0040_0031; iImm = 32'h3;
        #1; check("jalr_bit0", {31'h0, oTrap}, 32'h0);
        step(); check("jalr_pc", oPC, 32'h0040_0034);
        clr();
        iLoadMis = 1; iIllegal = 1; iBadAddr = 32'h1003; step(); clr();
        rd("prio_ucause", 12'h042, 32'h2);
        rd("prio_utval", 12'h043, 32'h0);
        iUret = 1; step(); clr();
        check("prio_ret_pc", oPC, 32'h0040_0034);
        iLoadMis = 1; iBadAddr = 32'h1003; step(); clr();
        rd("ld_ucause", 12'h042, 32'h4);
        rd("ld_utval", 12'h043, 32'h1003);
        iUret = 1; step(); clr();
        iStoreMis = 1; iBadAddr = 32'h2002; step(); clr();
        rd("st_ucause", 12'h042, 32'h6);
        rd("st_utval", 12'h043, 32'h2002);
        iUret = 1; step(); clr();
        step(); step();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
